// File: rtl/ray_generator_pkg.sv
// Shared fixed-point types, constants and saturation helpers for the ray generator.
package ray_generator_pkg;

   localparam int FXP_WIDTH  = 20;
   localparam int FXP_Q_BITS = 12;

   typedef logic signed [FXP_WIDTH-1:0]   fxp_t;
   typedef logic signed [2*FXP_WIDTH-1:0] fxp_wide_t;

   localparam fxp_t FXP_MIN = 20'sh80000;
   localparam fxp_t FXP_MAX = 20'sh7FFFF;

   typedef struct packed {
      fxp_t x;
      fxp_t y;
      fxp_t z;
   } vec3_t;

   typedef struct packed {
      vec3_t origin;
      vec3_t direction;
   } ray_t;

   typedef struct packed {
      vec3_t origin;
      vec3_t forward;
      vec3_t up;
      fxp_t  fov;
      fxp_t  aspect_ratio;
   } camera_t;

   typedef struct packed {
      fxp_t r;
      fxp_t g;
      fxp_t b;
   } color_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } gen_state_t;

   localparam vec3_t   VEC3_ZERO = {$bits(vec3_t){1'b0}};
   localparam ray_t    RAY_ZERO  = {$bits(ray_t){1'b0}};
   localparam camera_t CAM_ZERO  = {$bits(camera_t){1'b0}};

   // Clamp a double-width signed value into the fixed-point range.
   function automatic fxp_t sat_wide(input fxp_wide_t v);
      fxp_t r;
      if (v > fxp_wide_t'(FXP_MAX)) begin
         r = FXP_MAX;
      end else if (v < fxp_wide_t'(FXP_MIN)) begin
         r = FXP_MIN;
      end else begin
         r = v[FXP_WIDTH-1:0];
      end
      return r;
   endfunction

   // Saturating addition; the sum is formed at double width so it never wraps.
   function automatic fxp_t sat_add(input fxp_t a, input fxp_t b);
      fxp_wide_t s;
      s = fxp_wide_t'(a) + fxp_wide_t'(b);
      return sat_wide(s);
   endfunction

   // Saturating subtraction a - b.
   function automatic fxp_t sat_sub(input fxp_t a, input fxp_t b);
      fxp_wide_t s;
      s = fxp_wide_t'(a) - fxp_wide_t'(b);
      return sat_wide(s);
   endfunction

endpackage

// File: rtl/ray_generator_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by Q_BITS
// (rounds toward negative infinity), then clamp into [MIN, MAX].
module fxp_mul_sat
   import ray_generator_pkg::*;
#(
   parameter int               WIDTH  = FXP_WIDTH,
   parameter int               Q_BITS = FXP_Q_BITS,
   parameter logic [WIDTH-1:0] MIN    = 20'h80000,
   parameter logic [WIDTH-1:0] MAX    = 20'h7FFFF
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p
);

   localparam logic signed [2*WIDTH-1:0] MAX_W = {{WIDTH{MAX[WIDTH-1]}}, MAX};
   localparam logic signed [2*WIDTH-1:0] MIN_W = {{WIDTH{MIN[WIDTH-1]}}, MIN};

   logic signed [2*WIDTH-1:0] prod_s;
   logic signed [2*WIDTH-1:0] shr_s;

   // Multiply at double width, rescale, and saturate.
   always_comb begin
      prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      shr_s  = prod_s >>> Q_BITS;
      if (shr_s > MAX_W) begin
         p = MAX;
      end else if (shr_s < MIN_W) begin
         p = MIN;
      end else begin
         p = shr_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/ray_generator.sv
// Primary-ray generator: walks the image in raster order and emits one
// unnormalized camera ray per pixel through a 3-stage fixed-point pipeline.
module ray_generator
   import ray_generator_pkg::*;
#(
   parameter int               WIDTH        = FXP_WIDTH,
   parameter int               Q_BITS       = FXP_Q_BITS,
   parameter logic [WIDTH-1:0] MIN          = 20'h80000,
   parameter logic [WIDTH-1:0] MAX          = 20'h7FFFF,
   parameter int               PIXEL_WIDTH  = 3,
   parameter int               PIXEL_HEIGHT = 3
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    start,
   input  camera_t cam,
   output ray_t    ray_out,
   output logic    valid_out
);

   localparam logic [2*WIDTH-1:0]        ONE_WIDE = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic signed [2*WIDTH-1:0] W_WIDE   = $signed(ONE_WIDE << PIXEL_WIDTH);
   localparam logic signed [2*WIDTH-1:0] H_WIDE   = $signed(ONE_WIDE << PIXEL_HEIGHT);
   localparam logic [PIXEL_WIDTH-1:0]    PX_LAST  = {PIXEL_WIDTH{1'b1}};
   localparam logic [PIXEL_HEIGHT-1:0]   PY_LAST  = {PIXEL_HEIGHT{1'b1}};
   localparam logic [PIXEL_WIDTH-1:0]    PX_ONE   = {{(PIXEL_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PIXEL_HEIGHT-1:0]   PY_ONE   = {{(PIXEL_HEIGHT-1){1'b0}}, 1'b1};

   gen_state_t               state_r;
   logic [PIXEL_WIDTH-1:0]   px_r;
   logic [PIXEL_HEIGHT-1:0]  py_r;
   camera_t                  cam_r;
   logic                     start_prev_r;
   logic                     v1_r;
   logic                     v2_r;

   // Stage 1 combinational results.
   logic signed [2*WIDTH-1:0] hnum_s;
   logic signed [2*WIDTH-1:0] vnum_s;
   fxp_t                      un_s;
   fxp_t                      vn_s;
   fxp_t                      cx_a_s [6];
   fxp_t                      cx_b_s [6];
   fxp_t                      cx_p_s [6];
   vec3_t                     right_s;

   // Stage 1 registers.
   fxp_t                      un_r;
   fxp_t                      vn_r;
   vec3_t                     right_r;

   // Stage 2 combinational results and registers.
   fxp_t                      ua_s;
   fxp_t                      u_s;
   fxp_t                      v_s;
   fxp_t                      u_r;
   fxp_t                      v_r;
   vec3_t                     right2_r;

   // Stage 3 combinational results.
   fxp_t                      s3_a_s [6];
   fxp_t                      s3_b_s [6];
   fxp_t                      s3_p_s [6];
   vec3_t                     dir_s;

   // Frame sequencer: start-edge detect, camera latch, raster counters, issue valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         px_r         <= {PIXEL_WIDTH{1'b0}};
         py_r         <= {PIXEL_HEIGHT{1'b0}};
         cam_r        <= CAM_ZERO;
         start_prev_r <= 1'b1;
         v1_r         <= 1'b0;
      end else begin
         start_prev_r <= start;
         case (state_r)
            IDLE: begin
               v1_r <= 1'b0;
               if (start && !start_prev_r) begin
                  cam_r   <= cam;
                  px_r    <= {PIXEL_WIDTH{1'b0}};
                  py_r    <= {PIXEL_HEIGHT{1'b0}};
                  state_r <= RUN;
               end
            end
            RUN: begin
               v1_r <= 1'b1;
               if (px_r == PX_LAST) begin
                  px_r <= {PIXEL_WIDTH{1'b0}};
                  if (py_r == PY_LAST) begin
                     state_r <= DRAIN;
                  end else begin
                     py_r <= py_r + PY_ONE;
                  end
               end else begin
                  px_r <= px_r + PX_ONE;
               end
            end
            DRAIN: begin
               v1_r <= 1'b0;
               // The latched camera feeds stages 2 and 3, so hold it until they are empty.
               if (!v1_r && !v2_r) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               v1_r    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Stage 1 datapath: NDC coordinates of the current pixel and cross-product operands.
   always_comb begin
      hnum_s = $signed({{(2*WIDTH-PIXEL_WIDTH-1){1'b0}}, px_r, 1'b1}) - W_WIDE;
      vnum_s = H_WIDE - $signed({{(2*WIDTH-PIXEL_HEIGHT-1){1'b0}}, py_r, 1'b1});
      un_s   = sat_wide((hnum_s <<< Q_BITS) >>> PIXEL_WIDTH);
      vn_s   = sat_wide((vnum_s <<< Q_BITS) >>> PIXEL_HEIGHT);
      cx_a_s[0] = cam_r.up.y;  cx_b_s[0] = cam_r.forward.z;
      cx_a_s[1] = cam_r.up.z;  cx_b_s[1] = cam_r.forward.y;
      cx_a_s[2] = cam_r.up.z;  cx_b_s[2] = cam_r.forward.x;
      cx_a_s[3] = cam_r.up.x;  cx_b_s[3] = cam_r.forward.z;
      cx_a_s[4] = cam_r.up.x;  cx_b_s[4] = cam_r.forward.y;
      cx_a_s[5] = cam_r.up.y;  cx_b_s[5] = cam_r.forward.x;
      right_s.x = sat_sub(cx_p_s[0], cx_p_s[1]);
      right_s.y = sat_sub(cx_p_s[2], cx_p_s[3]);
      right_s.z = sat_sub(cx_p_s[4], cx_p_s[5]);
   end

   for (genvar g = 0; g < 6; g++) begin : g_cross
      fxp_mul_sat #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .MIN(MIN), .MAX(MAX)) u_mul (
         .a (cx_a_s[g]),
         .b (cx_b_s[g]),
         .p (cx_p_s[g])
      );
   end

   // Stage 2: screen offsets u = (un*aspect)*fov and v = vn*fov.
   fxp_mul_sat #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .MIN(MIN), .MAX(MAX)) u_mul_ua (
      .a (un_r),
      .b (cam_r.aspect_ratio),
      .p (ua_s)
   );

   fxp_mul_sat #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .MIN(MIN), .MAX(MAX)) u_mul_u (
      .a (ua_s),
      .b (cam_r.fov),
      .p (u_s)
   );

   fxp_mul_sat #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .MIN(MIN), .MAX(MAX)) u_mul_v (
      .a (vn_r),
      .b (cam_r.fov),
      .p (v_s)
   );

   // Stage 3 datapath: direction = forward + u*right + v*up, saturated at every add.
   always_comb begin
      s3_a_s[0] = u_r;  s3_b_s[0] = right2_r.x;
      s3_a_s[1] = u_r;  s3_b_s[1] = right2_r.y;
      s3_a_s[2] = u_r;  s3_b_s[2] = right2_r.z;
      s3_a_s[3] = v_r;  s3_b_s[3] = cam_r.up.x;
      s3_a_s[4] = v_r;  s3_b_s[4] = cam_r.up.y;
      s3_a_s[5] = v_r;  s3_b_s[5] = cam_r.up.z;
      dir_s.x = sat_add(sat_add(cam_r.forward.x, s3_p_s[0]), s3_p_s[3]);
      dir_s.y = sat_add(sat_add(cam_r.forward.y, s3_p_s[1]), s3_p_s[4]);
      dir_s.z = sat_add(sat_add(cam_r.forward.z, s3_p_s[2]), s3_p_s[5]);
   end

   for (genvar g = 0; g < 6; g++) begin : g_dir
      fxp_mul_sat #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .MIN(MIN), .MAX(MAX)) u_mul (
         .a (s3_a_s[g]),
         .b (s3_b_s[g]),
         .p (s3_p_s[g])
      );
   end

   // Pipeline registers; each stage only loads when fed, so ray_out holds between frames.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         un_r      <= {WIDTH{1'b0}};
         vn_r      <= {WIDTH{1'b0}};
         right_r   <= VEC3_ZERO;
         u_r       <= {WIDTH{1'b0}};
         v_r       <= {WIDTH{1'b0}};
         right2_r  <= VEC3_ZERO;
         v2_r      <= 1'b0;
         valid_out <= 1'b0;
         ray_out   <= RAY_ZERO;
      end else begin
         v2_r      <= v1_r;
         valid_out <= v2_r;
         if (state_r == RUN) begin
            un_r    <= un_s;
            vn_r    <= vn_s;
            right_r <= right_s;
         end
         if (v1_r) begin
            u_r      <= u_s;
            v_r      <= v_s;
            right2_r <= right_r;
         end
         if (v2_r) begin
            ray_out.origin    <= cam_r.origin;
            ray_out.direction <= dir_s;
         end
      end
   end

endmodule

// File: tb/tb_ray_generator.sv
// Self-checking bench for ray_generator: per-frame expected rays come from an
// arithmetic model of the camera equations; one compare process checks every cycle.
module tb_ray_generator;
   import ray_generator_pkg::*;

   localparam int     W  = 8;
   localparam int     H  = 8;
   localparam longint QS = 4096;
   localparam longint LO = -524288;
   localparam longint HI = 524287;

   logic    clk = 1'b0;
   logic    reset;
   logic    start;
   camera_t cam;
   ray_t    ray_out;
   logic    valid_out;

   int      total = 0;
   int      bad = 0;
   int      edge_cnt = 0;
   int      start_edge = -1000;
   bit      frame_on = 1'b0;
   longint  exp_dx [64];
   longint  exp_dy [64];
   longint  exp_dz [64];
   longint  exp_org;
   camera_t tc;

   ray_generator dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cam       (cam),
      .ray_out   (ray_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic longint sx(input logic [19:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint fl_div(input longint x, input longint d);
      longint q;
      q = x / d;
      if ((x % d) != 0 && x < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint sat(input longint x);
      if (x > HI) return HI;
      if (x < LO) return LO;
      return x;
   endfunction

   function automatic longint fmul(input longint a, input longint b);
      return sat(fl_div(a * b, QS));
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected direction for every pixel of a frame from the camera equations.
   task automatic build_model(input camera_t c);
      longint fx, fy, fz, ux, uy, uz, rx, ry, rz, un, vn, u, v;
      fx = sx(c.forward.x); fy = sx(c.forward.y); fz = sx(c.forward.z);
      ux = sx(c.up.x);      uy = sx(c.up.y);      uz = sx(c.up.z);
      rx = sat(fmul(uy, fz) - fmul(uz, fy));
      ry = sat(fmul(uz, fx) - fmul(ux, fz));
      rz = sat(fmul(ux, fy) - fmul(uy, fx));
      for (int py = 0; py < H; py++) begin
         for (int px = 0; px < W; px++) begin
            un = sat(fl_div(longint'(2 * px + 1 - W) * QS, W));
            vn = sat(fl_div(longint'(H - 2 * py - 1) * QS, H));
            u  = fmul(fmul(un, sx(c.aspect_ratio)), sx(c.fov));
            v  = fmul(vn, sx(c.fov));
            exp_dx[py * W + px] = sat(sat(fx + fmul(u, rx)) + fmul(v, ux));
            exp_dy[py * W + px] = sat(sat(fy + fmul(u, ry)) + fmul(v, uy));
            exp_dz[py * W + px] = sat(sat(fz + fmul(u, rz)) + fmul(v, uz));
         end
      end
      exp_org = longint'(c.origin);
   endtask

   function automatic fxp_t rnd_fx();
      case ($urandom_range(0, 2))
         0:       return fxp_t'($urandom);
         1:       return fxp_t'(int'($urandom_range(0, 16384)) - 8192);
         default: return fxp_t'(0);
      endcase
   endfunction

   function automatic camera_t rnd_cam();
      camera_t c;
      c.origin.x = rnd_fx();  c.origin.y = rnd_fx();  c.origin.z = rnd_fx();
      c.forward.x = rnd_fx(); c.forward.y = rnd_fx(); c.forward.z = rnd_fx();
      c.up.x = rnd_fx();      c.up.y = rnd_fx();      c.up.z = rnd_fx();
      c.fov = fxp_t'($urandom_range(0, 8192));
      c.aspect_ratio = fxp_t'($urandom_range(0, 8192));
      return c;
   endfunction

   // Compare process: valid_out must follow the frame schedule, and each valid ray must match the model.
   always @(negedge clk) begin
      int k;
      bit ev;
      k  = edge_cnt - start_edge - 3;
      ev = frame_on && (k >= 0) && (k < W * H);
      chk("valid_out", longint'(valid_out), longint'(ev));
      if (ev && valid_out) begin
         chk("dir_x", sx(ray_out.direction.x), exp_dx[k]);
         chk("dir_y", sx(ray_out.direction.y), exp_dy[k]);
         chk("dir_z", sx(ray_out.direction.z), exp_dz[k]);
         chk("origin", longint'(ray_out.origin), exp_org);
      end
   end

   // Raise start (previous cycle had it low) and arm the model for the frame.
   task automatic launch(input camera_t c);
      @(negedge clk);
      build_model(c);
      cam        = c;
      start      = 1'b1;
      start_edge = edge_cnt + 1;
      frame_on   = 1'b1;
   endtask

   // Let the frame run out; optionally scramble cam/start while the frame is busy.
   task automatic finish_frame(input bit scramble);
      for (int i = 0; i < 72; i++) begin
         @(negedge clk);
         if (scramble && i < 58) begin
            cam   = rnd_cam();
            start = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b1;
         end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      camera_t sc;
      tc = CAM_ZERO;
      tc.origin.z    = 20'shFE000;
      tc.forward.z   = 20'sh01000;
      tc.up.y        = 20'sh01000;
      tc.fov         = 20'sd1934;
      tc.aspect_ratio = 20'sh01000;

      reset = 1'b0;
      start = 1'b0;
      cam   = CAM_ZERO;
      repeat (3) @(negedge clk);
      chk("reset_valid", longint'(valid_out), 0);
      chk("reset_origin", longint'(ray_out.origin), 0);
      chk("reset_dir", longint'(ray_out.direction), 0);

      // Release reset with start already high: nothing may happen.
      start = 1'b1;
      reset = 1'b1;
      repeat (8) @(negedge clk);
      start = 1'b0;
      @(negedge clk);

      // Test camera frame, model pinned against hand-computed rays.
      launch(tc);
      chk("pin_r0_x", exp_dx[0], sx(20'hFF963));
      chk("pin_r0_y", exp_dy[0], sx(20'h0069C));
      chk("pin_r0_z", exp_dz[0], sx(20'h01000));
      chk("pin_r27_x", exp_dx[27], sx(20'hFFF0E));
      chk("pin_r27_y", exp_dy[27], sx(20'h000F1));
      chk("pin_r63_x", exp_dx[63], sx(20'h0069C));
      chk("pin_r63_y", exp_dy[63], sx(20'hFF963));
      chk("pin_r63_z", exp_dz[63], sx(20'h01000));
      finish_frame(1'b0);

      // Randomized cameras, with cam/start disturbed mid-frame.
      for (int f = 0; f < 5; f++) begin
         launch(rnd_cam());
         finish_frame(f[0]);
      end

      // Saturation camera.
      sc = CAM_ZERO;
      sc.origin    = rnd_cam().origin;
      sc.forward.x = 20'sh7F000;
      sc.up.y      = 20'sh7F000;
      sc.fov       = 20'sd1934;
      sc.aspect_ratio = 20'sh01000;
      launch(sc);
      chk("sat_pin_x", exp_dx[0], sx(20'h7F000));
      finish_frame(1'b0);

      // Reset in the middle of a frame, right as ray 10 is presented.
      launch(tc);
      repeat (14) @(negedge clk);
      #1;
      frame_on = 1'b0;
      reset    = 1'b0;
      #1;
      chk("abort_valid", longint'(valid_out), 0);
      chk("abort_origin", longint'(ray_out.origin), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      launch(tc);
      finish_frame(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
